// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the VRAM arbiter.
// Contents:
//   arb_state_t  arbiter window state
//   mem_op_t     kind of controller command
//   VDP_ADDR_W   native VDP address width before zero extension
package vram_arb_pkg;
    typedef enum logic [1:0] {IDLE, VDP_CMD, AUX_CMD, GAP} arb_state_t;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE, OP_REFRESH} mem_op_t;
    localparam int VDP_ADDR_W = 19;
endpackage

// File: rtl/vdp_req_capture.sv
// vdp_req_capture: turns the VDP level strobes into a single pending request.
// Ports:
//   i_clk, i_reset_n                 clock, async active-low reset
//   i_read, i_write, i_refresh       VDP level strobes; a rising edge is a request
//   i_addr, i_data                   VDP address/write data, latched on the request edge
//   i_clear                          arbiter has taken the pending request
//   o_pend, o_op, o_addr, o_data     pending flag and the latched request
module vdp_req_capture
    import vram_arb_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic                  i_refresh,
    input  logic [VDP_ADDR_W-1:0] i_addr,
    input  logic [7:0]            i_data,
    input  logic                  i_clear,
    output logic                  o_pend,
    output mem_op_t               o_op,
    output logic [VDP_ADDR_W-1:0] o_addr,
    output logic [7:0]            o_data
);
    logic [2:0] r_prev;
    logic [2:0] w_rise;
    mem_op_t    w_op;

    assign w_rise = {i_write, i_read, i_refresh} & ~r_prev;
    // Simultaneous edges resolve write > read > refresh.
    assign w_op = w_rise[2] ? OP_WRITE : w_rise[1] ? OP_READ : w_rise[0] ? OP_REFRESH : OP_NONE;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev <= '0;
            o_pend <= 1'b0;
            o_op   <= OP_NONE;
            o_addr <= '0;
            o_data <= '0;
        end else begin
            r_prev <= {i_write, i_read, i_refresh};
            // A fresh edge beats the clear so a request landing on the dispatch clock is kept.
            if (w_op != OP_NONE) begin
                o_pend <= 1'b1;
                o_op   <= w_op;
                o_addr <= i_addr;
                o_data <= i_data;
            end else if (i_clear) begin
                o_pend <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one SDRAM controller port between the VDP (always first) and an aux host/DMA port.
// Ports:
//   i_clk, i_reset_n                          controller clock, async active-low reset
//   i_vdp_read, i_vdp_write, i_vdp_refresh    VDP level strobes (rising edge = request)
//   i_vdp_addr, i_vdp_din8                    VDP address/write data, captured on the request edge
//   o_vdp_dout16                              last VDP read data, held until the next VDP read
//   i_aux_req, i_aux_wr, i_aux_addr, i_aux_din8  aux request, held stable until o_aux_ack
//   o_aux_ack, o_aux_dout16                   one-clock completion pulse and aux read data
//   o_mem_read, o_mem_write, o_mem_refresh    controller command strobes, one at a time
//   o_mem_addr, o_mem_din8                    controller address and write data
//   i_mem_dout16                              controller read data, valid on the last window cycle
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int CMD_CYCLES   = 6,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_vdp_read,
    input  logic                  i_vdp_write,
    input  logic                  i_vdp_refresh,
    input  logic [VDP_ADDR_W-1:0] i_vdp_addr,
    input  logic [7:0]            i_vdp_din8,
    output logic [15:0]           o_vdp_dout16,
    input  logic                  i_aux_req,
    input  logic                  i_aux_wr,
    input  logic [ADDR_W-1:0]     i_aux_addr,
    input  logic [7:0]            i_aux_din8,
    output logic                  o_aux_ack,
    output logic [15:0]           o_aux_dout16,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_refresh,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [7:0]            o_mem_din8,
    input  logic [15:0]           i_mem_dout16
);
    localparam int CNT_W = $clog2(CMD_CYCLES + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_CYCLES - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    arb_state_t            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [STV_W-1:0]      r_starve;
    logic                  r_ack_hold;
    logic                  w_pend;
    mem_op_t               w_op;
    logic [VDP_ADDR_W-1:0] w_addr;
    logic [7:0]            w_data;
    logic                  w_idle;
    logic                  w_aux_ok;
    logic                  w_steal;
    logic                  w_go_vdp;
    logic                  w_go_aux;
    logic                  w_clear;
    logic                  w_last;

    vdp_req_capture u_cap (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_read    (i_vdp_read),
        .i_write   (i_vdp_write),
        .i_refresh (i_vdp_refresh),
        .i_addr    (i_vdp_addr),
        .i_data    (i_vdp_din8),
        .i_clear   (w_clear),
        .o_pend    (w_pend),
        .o_op      (w_op),
        .o_addr    (w_addr),
        .o_data    (w_data)
    );

    // GAP is the single all-strobes-low clock after a window; it dispatches exactly like IDLE.
    assign w_idle   = (r_state == IDLE) || (r_state == GAP);
    assign w_aux_ok = i_aux_req && !r_ack_hold;
    // Once aux has waited through STARVE_LIMIT VDP windows, a pending refresh yields its slot.
    assign w_steal  = w_pend && (w_op == OP_REFRESH) && (r_starve == STV_MAX) && w_aux_ok;
    assign w_go_vdp = w_idle && w_pend && !w_steal;
    assign w_go_aux = w_idle && w_aux_ok && (!w_pend || w_steal);
    // Either dispatch path consumes the pending VDP request (a stolen refresh is dropped).
    assign w_clear  = w_idle && w_pend;
    assign w_last   = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_starve      <= '0;
            r_ack_hold    <= 1'b0;
            o_vdp_dout16  <= '0;
            o_aux_ack     <= 1'b0;
            o_aux_dout16  <= '0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_mem_refresh <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_din8    <= '0;
        end else begin
            o_aux_ack  <= 1'b0;
            r_ack_hold <= r_ack_hold && i_aux_req;
            if (!i_aux_req)
                r_starve <= '0;
            case (r_state)
                IDLE, GAP: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    if (w_go_vdp) begin
                        r_state       <= VDP_CMD;
                        o_mem_read    <= (w_op == OP_READ);
                        o_mem_write   <= (w_op == OP_WRITE);
                        o_mem_refresh <= (w_op == OP_REFRESH);
                        o_mem_addr    <= ADDR_W'(w_addr);
                        o_mem_din8    <= w_data;
                        if (i_aux_req && r_starve != STV_MAX)
                            r_starve <= r_starve + 1'b1;
                    end else if (w_go_aux) begin
                        r_state     <= AUX_CMD;
                        o_mem_read  <= !i_aux_wr;
                        o_mem_write <= i_aux_wr;
                        o_mem_addr  <= i_aux_addr;
                        o_mem_din8  <= i_aux_din8;
                        r_starve    <= '0;
                    end
                end
                VDP_CMD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state       <= GAP;
                        o_mem_read    <= 1'b0;
                        o_mem_write   <= 1'b0;
                        o_mem_refresh <= 1'b0;
                        if (o_mem_read)
                            o_vdp_dout16 <= i_mem_dout16;
                    end
                end
                AUX_CMD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= GAP;
                        o_mem_read  <= 1'b0;
                        o_mem_write <= 1'b0;
                        o_aux_ack   <= 1'b1;
                        // Hold off re-serving until the requester drops aux_req.
                        r_ack_hold  <= 1'b1;
                        if (o_mem_read)
                            o_aux_dout16 <= i_mem_dout16;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
